// File: rtl/phased_tag_pkg.sv
// Shared parameters and FSM state encoding for the phased tag lookup stage.
package phased_tag_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 20;
    localparam int unsigned SET_W  = 6;
    localparam int unsigned OFF_W  = 6;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned WAY_W  = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TAG       = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        DATA      = 3'd4
    } state_t;

endpackage

// File: rtl/phased_tag_array.sv
// 4-way tag/valid store: one combinational read port (all ways of a set),
// one registered write port, and a bulk valid-clear.
module phased_tag_array
    import phased_tag_pkg::*;
#(
    parameter int unsigned TAG_W = phased_tag_pkg::TAG_W,
    parameter int unsigned SET_W = phased_tag_pkg::SET_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_clear,
    input  logic [SET_W-1:0]                       i_rd_set,
    output logic [phased_tag_pkg::WAYS*TAG_W-1:0]  o_rd_tags,
    output logic [phased_tag_pkg::WAYS-1:0]        o_rd_valid,
    input  logic                                   i_wr_en,
    input  logic [SET_W-1:0]                       i_wr_set,
    input  logic [phased_tag_pkg::WAY_W-1:0]       i_wr_way,
    input  logic [TAG_W-1:0]                       i_wr_tag
);

    localparam int unsigned SETS = 1 << SET_W;

    logic [TAG_W-1:0]            r_tag [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]   r_valid;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_set][i_wr_way] <= i_wr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_set][i_wr_way] <= 1'b1;
        end
    end

    always_comb begin
        o_rd_tags = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            o_rd_tags[i*TAG_W +: TAG_W] = r_tag[i_rd_set][i];
        end
    end

    assign o_rd_valid = r_valid[i_rd_set];

endmodule

// File: rtl/phased_tag_stage.sv
// Two-phase cache lookup: tag compare in TAG, single-cycle data enable in DATA,
// with miss refill, lowest-invalid/round-robin victim choice and deferred flush.
module phased_tag_stage
    import phased_tag_pkg::*;
#(
    parameter int unsigned TAG_W = phased_tag_pkg::TAG_W,
    parameter int unsigned SET_W = phased_tag_pkg::SET_W,
    parameter int unsigned OFF_W = phased_tag_pkg::OFF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             flush,
    output logic             data_en,
    output logic [1:0]       data_way,
    output logic [SET_W-1:0] data_set,
    output logic             resp_hit,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             fill_valid
);

    localparam int unsigned SETS   = 1 << SET_W;
    localparam int unsigned LINE_W = TAG_W + SET_W;

    if (TAG_W + SET_W + OFF_W != ADDR_W) begin : g_bad_split
        $error("phased_tag_stage: TAG_W+SET_W+OFF_W must equal 32");
    end

    state_t                    r_state;
    state_t                    w_next_state;
    logic [LINE_W-1:0]         r_line;
    logic [SETS-1:0][WAY_W-1:0] r_ptr;
    logic [WAY_W-1:0]          r_victim;
    logic                      r_set_full;
    logic                      r_flush_pend;
    logic [WAY_W-1:0]          r_data_way;
    logic [SET_W-1:0]          r_data_set;
    logic                      r_resp_hit;

    logic [TAG_W-1:0]          w_tag;
    logic [SET_W-1:0]          w_set;
    logic [WAYS*TAG_W-1:0]     w_rd_tags;
    logic [WAYS-1:0]           w_rd_valid;
    logic                      w_hit;
    logic [WAY_W-1:0]          w_hit_way;
    logic                      w_any_inv;
    logic [WAY_W-1:0]          w_inv_way;
    logic [WAY_W-1:0]          w_victim;
    logic                      w_accept;
    logic                      w_flush_now;
    logic                      w_wr_en;

    assign w_tag = r_line[LINE_W-1 -: TAG_W];
    assign w_set = r_line[SET_W-1:0];

    phased_tag_array #(
        .TAG_W (TAG_W),
        .SET_W (SET_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_flush_now),
        .i_rd_set   (w_set),
        .o_rd_tags  (w_rd_tags),
        .o_rd_valid (w_rd_valid),
        .i_wr_en    (w_wr_en),
        .i_wr_set   (w_set),
        .i_wr_way   (r_victim),
        .i_wr_tag   (w_tag)
    );

    // A flush arriving outside IDLE is parked and applied on the IDLE cycle,
    // which also holds req_ready low so no request slips in ahead of it.
    assign w_flush_now = (r_state == IDLE) && (flush || r_flush_pend);
    assign req_ready   = rst_n && (r_state == IDLE) && !flush && !r_flush_pend;
    assign w_accept    = req_valid && req_ready;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_any_inv = 1'b0;
        w_inv_way = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_hit && w_rd_valid[i] && (w_rd_tags[i*TAG_W +: TAG_W] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!w_any_inv && !w_rd_valid[i]) begin
                w_any_inv = 1'b1;
                w_inv_way = WAY_W'(i);
            end
        end
        w_victim = w_any_inv ? w_inv_way : r_ptr[w_set];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        unique case (r_state)
            IDLE:      if (w_accept) w_next_state = TAG;
            TAG:       w_next_state = w_hit ? DATA : MISS_REQ;
            MISS_REQ:  if (mem_req_ready) w_next_state = MISS_WAIT;
            MISS_WAIT: begin
                if (fill_valid) begin
                    w_wr_en      = 1'b1;
                    w_next_state = DATA;
                end
            end
            DATA:      w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line       <= '0;
            r_ptr        <= '0;
            r_victim     <= '0;
            r_set_full   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_data_way   <= '0;
            r_data_set   <= '0;
            r_resp_hit   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_line <= req_addr[31:OFF_W];
            end
            if (r_state == TAG) begin
                r_victim   <= w_victim;
                r_set_full <= &w_rd_valid;
                if (w_hit) begin
                    r_data_way <= w_hit_way;
                    r_data_set <= w_set;
                    r_resp_hit <= 1'b1;
                end
            end
            if (w_wr_en) begin
                r_data_way <= r_victim;
                r_data_set <= w_set;
                r_resp_hit <= 1'b0;
                if (r_set_full) begin
                    r_ptr[w_set] <= r_ptr[w_set] + 2'd1;
                end
            end
            if (w_flush_now) begin
                r_flush_pend <= 1'b0;
                r_ptr        <= '0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign data_en       = (r_state == DATA);
    assign data_way      = r_data_way;
    assign data_set      = r_data_set;
    assign resp_hit      = r_resp_hit;
    assign mem_req_valid = (r_state == MISS_REQ);
    assign mem_req_addr  = {r_line, {OFF_W{1'b0}}};

endmodule

// File: tb/tb_phased_tag_stage.sv
// Directed bench for phased_tag_stage: hit/miss latency, replacement order,
// backpressure, flush deferral and reset during refill.
module tb_phased_tag_stage;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        data_en;
    logic [1:0]  data_way;
    logic [5:0]  data_set;
    logic        resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        fill_valid;

    int n_pass  = 0;
    int n_total = 0;

    phased_tag_stage #(
        .TAG_W (20),
        .SET_W (6),
        .OFF_W (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .flush         (flush),
        .data_en       (data_en),
        .data_way      (data_way),
        .data_set      (data_set),
        .resp_hit      (resp_hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .fill_valid    (fill_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1ns after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; fill_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    // Returns in the cycle after the accepting edge (the TAG cycle).
    task automatic accept_req(input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic run_lookup(input logic [31:0] addr, input int fill_delay,
                              output int lat, output bit saw_mem, output logic [31:0] maddr,
                              output logic [1:0] way, output logic [5:0] st,
                              output logic hit, output bit tmo);
        bit ok;
        int phase;
        int wcnt;
        saw_mem = 1'b0; maddr = '0; way = '0; st = '0; hit = 1'b0; tmo = 1'b1;
        phase = 0; wcnt = 0; lat = 1;
        accept_req(addr, ok);
        if (ok) begin
            for (int c = 2; c <= 60; c++) begin
                step();
                mem_req_ready = 1'b0;
                fill_valid    = 1'b0;
                if (data_en) begin
                    lat = c; way = data_way; st = data_set; hit = resp_hit; tmo = 1'b0;
                    break;
                end
                if (mem_req_valid) begin
                    saw_mem = 1'b1; maddr = mem_req_addr; mem_req_ready = 1'b1; phase = 1;
                end else if (phase == 1) begin
                    if (wcnt >= fill_delay) begin
                        fill_valid = 1'b1;
                        phase = 2;
                    end
                    wcnt++;
                end
            end
        end
        mem_req_ready = 1'b0;
        fill_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_1040; flush = 1'b0;
        mem_req_ready = 1'b1; fill_valid = 1'b1;
        repeat (2) step();
        n_total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else n_pass++;
        n_total++; if (data_en !== 1'b0) $display("FAIL reset_data_en got=%b exp=0", data_en); else n_pass++;
        n_total++; if (data_way !== 2'd0) $display("FAIL reset_data_way got=%0d exp=0", data_way); else n_pass++;
        n_total++; if (data_set !== 6'd0) $display("FAIL reset_data_set got=%0d exp=0", data_set); else n_pass++;
        n_total++; if (resp_hit !== 1'b0) $display("FAIL reset_resp_hit got=%b exp=0", resp_hit); else n_pass++;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); else n_pass++;
        n_total++; if (mem_req_addr !== 32'h0) $display("FAIL reset_mem_req_addr got=%h exp=0", mem_req_addr); else n_pass++;
        req_valid = 1'b0; mem_req_ready = 1'b0; fill_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_total++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", req_ready); else n_pass++;
    endtask

    task automatic test_cold_miss();
        int lat; bit saw; logic [31:0] ma; logic [1:0] w; logic [5:0] s; logic h; bit tmo;
        run_lookup(32'h0000_1040, 0, lat, saw, ma, w, s, h, tmo);
        n_total++; if (tmo !== 1'b0) $display("FAIL cold_timeout got=%b exp=0", tmo); else n_pass++;
        n_total++; if (saw !== 1'b1) $display("FAIL cold_mem_req got=%b exp=1", saw); else n_pass++;
        n_total++; if (ma !== 32'h0000_1040) $display("FAIL cold_mem_addr got=%h exp=00001040", ma); else n_pass++;
        n_total++; if (lat !== 4) $display("FAIL cold_latency got=%0d exp=4", lat); else n_pass++;
        n_total++; if (w !== 2'd0) $display("FAIL cold_way got=%0d exp=0", w); else n_pass++;
        n_total++; if (s !== 6'd1) $display("FAIL cold_set got=%0d exp=1", s); else n_pass++;
        n_total++; if (h !== 1'b0) $display("FAIL cold_hit got=%b exp=0", h); else n_pass++;
    endtask

    task automatic test_hit();
        int lat; bit saw; logic [31:0] ma; logic [1:0] w; logic [5:0] s; logic h; bit tmo;
        run_lookup(32'h0000_1044, 0, lat, saw, ma, w, s, h, tmo);
        n_total++; if (tmo !== 1'b0) $display("FAIL hit_timeout got=%b exp=0", tmo); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL hit_latency got=%0d exp=2", lat); else n_pass++;
        n_total++; if (saw !== 1'b0) $display("FAIL hit_mem_req got=%b exp=0", saw); else n_pass++;
        n_total++; if (w !== 2'd0) $display("FAIL hit_way got=%0d exp=0", w); else n_pass++;
        n_total++; if (s !== 6'd1) $display("FAIL hit_set got=%0d exp=1", s); else n_pass++;
        n_total++; if (h !== 1'b1) $display("FAIL hit_resp got=%b exp=1", h); else n_pass++;
        step();
        n_total++; if (data_en !== 1'b0) $display("FAIL hit_data_en_one_cycle got=%b exp=0", data_en); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL hit_back_idle got=%b exp=1", req_ready); else n_pass++;
    endtask

    task automatic test_replacement();
        logic [1:0] exp_way [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        int lat; bit saw; logic [31:0] ma; logic [1:0] w; logic [5:0] s; logic h; bit tmo;
        do_reset();
        for (int t = 1; t <= 5; t++) begin
            run_lookup(32'h0000_0040 + 32'(t) * 32'h1000, (t == 3) ? 2 : 0, lat, saw, ma, w, s, h, tmo);
            n_total++; if (tmo !== 1'b0 || saw !== 1'b1 || h !== 1'b0)
                $display("FAIL repl_fill%0d_miss tmo=%b mem=%b hit=%b exp 0/1/0", t, tmo, saw, h); else n_pass++;
            n_total++; if (w !== exp_way[t-1]) $display("FAIL repl_fill%0d_way got=%0d exp=%0d", t, w, exp_way[t-1]); else n_pass++;
        end
        n_total++; if (lat !== 4) $display("FAIL repl_latency got=%0d exp=4", lat); else n_pass++;
        run_lookup(32'h0000_5048, 0, lat, saw, ma, w, s, h, tmo);
        n_total++; if (tmo !== 1'b0 || h !== 1'b1 || w !== 2'd0 || saw !== 1'b0)
            $display("FAIL repl_hit_tag5 hit=%b way=%0d mem=%b exp hit=1 way=0 mem=0", h, w, saw); else n_pass++;
        run_lookup(32'h0000_1040, 0, lat, saw, ma, w, s, h, tmo);
        n_total++; if (tmo !== 1'b0 || h !== 1'b0 || saw !== 1'b1)
            $display("FAIL repl_tag1_evicted hit=%b mem=%b exp hit=0 mem=1", h, saw); else n_pass++;
        n_total++; if (w !== 2'd1) $display("FAIL repl_ptr_way got=%0d exp=1", w); else n_pass++;
        run_lookup(32'h0000_1080, 0, lat, saw, ma, w, s, h, tmo);
        n_total++; if (w !== 2'd0 || s !== 6'd2 || saw !== 1'b1)
            $display("FAIL repl_other_set way=%0d set=%0d mem=%b exp way=0 set=2 mem=1", w, s, saw); else n_pass++;
    endtask

    task automatic test_flush_idle();
        logic [1:0] exp_way [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        int lat; bit saw; logic [31:0] ma; logic [1:0] w; logic [5:0] s; logic h; bit tmo;
        step();
        flush = 1'b1;
        #1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL flush_idle_ready got=%b exp=0", req_ready); else n_pass++;
        step();
        flush = 1'b0;
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL flush_idle_ready_after got=%b exp=1", req_ready); else n_pass++;
        for (int t = 1; t <= 5; t++) begin
            run_lookup(32'h0000_0040 + 32'(t) * 32'h1000, 0, lat, saw, ma, w, s, h, tmo);
            n_total++; if (tmo !== 1'b0 || saw !== 1'b1 || w !== exp_way[t-1])
                $display("FAIL flush_refill%0d tmo=%b mem=%b way=%0d exp 0/1/%0d", t, tmo, saw, w, exp_way[t-1]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        accept_req(32'h0000_A0C4, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL bp_accept got=%b exp=1", ok); else n_pass++;
        step();
        for (int i = 0; i < 10; i++) begin
            n_total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_A0C0 || req_ready !== 1'b0)
                $display("FAIL bp_hold%0d valid=%b addr=%h ready=%b exp 1/0000a0c0/0", i, mem_req_valid, mem_req_addr, req_ready);
            else n_pass++;
            mem_req_ready = 1'b0;
            fill_valid    = (i == 3);
            step();
        end
        fill_valid    = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        n_total++; if (mem_req_valid !== 1'b0 || data_en !== 1'b0)
            $display("FAIL bp_wait valid=%b data_en=%b exp 0/0", mem_req_valid, data_en); else n_pass++;
        fill_valid = 1'b1;
        step();
        fill_valid = 1'b0;
        n_total++; if (data_en !== 1'b1 || data_way !== 2'd0 || data_set !== 6'd3 || resp_hit !== 1'b0)
            $display("FAIL bp_data en=%b way=%0d set=%0d hit=%b exp 1/0/3/0", data_en, data_way, data_set, resp_hit);
        else n_pass++;
    endtask

    task automatic test_flush_miss_wait();
        bit ok;
        int lat; bit saw; logic [31:0] ma; logic [1:0] w; logic [5:0] s; logic h; bit tmo;
        accept_req(32'h0000_B0C4, ok);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        fill_valid = 1'b1;
        step();
        fill_valid = 1'b0;
        n_total++; if (ok !== 1'b1 || data_en !== 1'b1 || data_way !== 2'd1 || resp_hit !== 1'b0)
            $display("FAIL fmw_data ok=%b en=%b way=%0d hit=%b exp 1/1/1/0", ok, data_en, data_way, resp_hit); else n_pass++;
        step();
        n_total++; if (req_ready !== 1'b0) $display("FAIL fmw_pending_ready got=%b exp=0", req_ready); else n_pass++;
        step();
        n_total++; if (req_ready !== 1'b1) $display("FAIL fmw_after_ready got=%b exp=1", req_ready); else n_pass++;
        run_lookup(32'h0000_A0C0, 0, lat, saw, ma, w, s, h, tmo);
        n_total++; if (tmo !== 1'b0 || saw !== 1'b1 || h !== 1'b0 || w !== 2'd0)
            $display("FAIL fmw_line_invalid tmo=%b mem=%b hit=%b way=%0d exp 0/1/0/0", tmo, saw, h, w); else n_pass++;
    endtask

    task automatic test_flush_with_fill();
        bit ok;
        int lat; bit saw; logic [31:0] ma; logic [1:0] w; logic [5:0] s; logic h; bit tmo;
        accept_req(32'h0000_C0C0, ok);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        fill_valid = 1'b1;
        step();
        flush = 1'b0;
        fill_valid = 1'b0;
        n_total++; if (ok !== 1'b1 || data_en !== 1'b1 || data_way !== 2'd1 || resp_hit !== 1'b0)
            $display("FAIL ffill_data ok=%b en=%b way=%0d hit=%b exp 1/1/1/0", ok, data_en, data_way, resp_hit); else n_pass++;
        step();
        n_total++; if (req_ready !== 1'b0) $display("FAIL ffill_pending_ready got=%b exp=0", req_ready); else n_pass++;
        run_lookup(32'h0000_C0C0, 0, lat, saw, ma, w, s, h, tmo);
        n_total++; if (tmo !== 1'b0 || saw !== 1'b1 || w !== 2'd0)
            $display("FAIL ffill_invalidated tmo=%b mem=%b way=%0d exp 0/1/0", tmo, saw, w); else n_pass++;
    endtask

    task automatic test_reset_mid_miss();
        bit ok;
        int lat; bit saw; logic [31:0] ma; logic [1:0] w; logic [5:0] s; logic h; bit tmo;
        step();
        accept_req(32'h0000_D104, ok);
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_total++; if (data_en !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || req_ready !== 1'b0)
            $display("FAIL rmm_outputs en=%b mv=%b ma=%h rdy=%b exp 0/0/0/0", data_en, mem_req_valid, mem_req_addr, req_ready);
        else n_pass++;
        n_total++; if (data_way !== 2'd0 || data_set !== 6'd0 || resp_hit !== 1'b0)
            $display("FAIL rmm_regs way=%0d set=%0d hit=%b exp 0/0/0", data_way, data_set, resp_hit); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        fill_valid = 1'b1;
        step();
        fill_valid = 1'b0;
        n_total++; if (data_en !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rmm_stray_fill en=%b rdy=%b exp 0/1", data_en, req_ready); else n_pass++;
        run_lookup(32'h0000_D104, 0, lat, saw, ma, w, s, h, tmo);
        n_total++; if (tmo !== 1'b0 || saw !== 1'b1 || ma !== 32'h0000_D100 || w !== 2'd0 || s !== 6'd4 || h !== 1'b0)
            $display("FAIL rmm_next_miss tmo=%b mem=%b addr=%h way=%0d set=%0d hit=%b exp 0/1/0000d100/0/4/0",
                     tmo, saw, ma, w, s, h);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_replacement();
        test_flush_idle();
        test_backpressure();
        test_flush_miss_wait();
        test_flush_with_fill();
        test_reset_mid_miss();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
